// File: rtl/keypad_matrix_emulator.sv
// rtl/keypad_matrix_emulator.sv - 4x4 keypad responder: queued key presses driven onto row lines
// Keys are held for HOLD_CYCLES then released for GAP_CYCLES; row drive is registered.
module keypad_matrix_emulator #(
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] fila,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       press_active,
  output logic       busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    IDLE_LVL  = ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    key_reg;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic          col_hit;
  logic [3:0]    fila_nxt;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  // Ready ignores a same-cycle pop so a full queue never takes a write.
  assign key_ready = reset & ~full;
  assign push      = key_valid & key_ready;
  assign pop       = (state == S_IDLE) & ~empty;

  assign press_active = (state == S_PRESS);
  assign busy         = (state != S_IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      key_reg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pop) key_reg <= mem[rd_ptr];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_nxt = S_PRESS;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      S_PRESS: begin
        if (cnt == '0) begin
          state_nxt = S_GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Column is sampled as-is; other active columns do not block the press.
  always_comb begin
    col_hit  = ACTIVE_LOW ? ~col[key_reg[1:0]] : col[key_reg[1:0]];
    fila_nxt = IDLE_LVL;
    if ((state == S_PRESS) && col_hit) fila_nxt[key_reg[3:2]] = ~ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (!reset) fila <= IDLE_LVL;
    else        fila <= fila_nxt;
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb/tb_keypad_matrix_emulator.sv - scoreboard bench for keypad_matrix_emulator
module tb_keypad_matrix_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col, key_code, fila;
  logic       key_valid, key_ready, press_active, busy;
  logic [3:0] col_h, key_code_h, fila_h;
  logic       key_valid_h, key_ready_h, press_active_h, busy_h;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    logic [3:0] val;
    int         len;
    int         start;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_matrix_emulator #(.ACTIVE_LOW(1'b1), .HOLD_CYCLES(8), .GAP_CYCLES(8), .FIFO_DEPTH(4)) dut_lo (
    .clk(clk), .reset(reset), .col(col), .fila(fila), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .press_active(press_active), .busy(busy)
  );

  keypad_matrix_emulator #(.ACTIVE_LOW(1'b0), .HOLD_CYCLES(8), .GAP_CYCLES(8), .FIFO_DEPTH(4)) dut_hi (
    .clk(clk), .reset(reset), .col(col_h), .fila(fila_h), .key_code(key_code_h),
    .key_valid(key_valid_h), .key_ready(key_ready_h), .press_active(press_active_h), .busy(busy_h)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each press seen on fila (active-low DUT) is popped against the scoreboard.
  logic [3:0] p_val;
  int         p_len, p_start;
  bit         in_p = 0, p_chg = 0;
  always @(negedge clk) begin
    exp_t e;
    if (fila !== 4'hF) begin
      if (!in_p) begin
        in_p = 1; p_val = fila; p_len = 0; p_start = cyc; p_chg = 0;
      end else if (fila !== p_val) p_chg = 1;
      p_len++;
    end else if (in_p) begin
      in_p = 0;
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_press: fila=%b len=%0d start=%0d", p_val, p_len, p_start);
      end else begin
        e = q.pop_front();
        if (p_val !== e.val || p_len != e.len || p_start != e.start || p_chg) begin
          nerr++;
          $display("FAIL press: got fila=%b len=%0d start=%0d chg=%0d expected fila=%b len=%0d start=%0d",
                   p_val, p_len, p_start, p_chg, e.val, e.len, e.start);
        end
      end
    end
  end

  task automatic push(input int sel, input logic [3:0] code, output int drv, output int acc);
    int w = 0;
    @(negedge clk);
    drv = cyc;
    if (sel == 0) begin key_code = code; key_valid = 1'b1; end
    else          begin key_code_h = code; key_valid_h = 1'b1; end
    while (!((sel == 0) ? key_ready : key_ready_h) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("push_timeout", 32'(w), 32'd0);
    @(posedge clk);
    #1;
    acc = cyc;
    key_valid = 1'b0;
    key_valid_h = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    @(negedge clk);
    while ((busy || busy_h) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk(name, 32'(w), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int drv, acc, c0, bad, n_on;
    logic [3:0] pat [3];
    logic [3:0] codes [6];
    logic [3:0] rows  [6];

    reset = 1'b0; col = 4'hF; key_code = 4'h5; key_valid = 1'b1;
    col_h = 4'h0; key_code_h = 4'h0; key_valid_h = 1'b0;

    // Reset with valid held high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fila", 32'(fila), 32'hF);
    chk("rst_fila_hi", 32'(fila_h), 32'h0);
    chk("rst_ready", 32'(key_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_press", 32'(press_active), 32'd0);
    key_valid = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", 32'(key_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Single key 6 with column 2 strobed
    col = 4'b1011;
    push(0, 4'h6, drv, acc);
    q.push_back('{val: 4'b1101, len: 8, start: drv + 3});
    wait_idle("single_idle");

    // Column selectivity: non-matching strobes never press
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b0111;
    col = pat[0];
    push(0, 4'h6, drv, acc);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      col = pat[i % 3];
      if (fila !== 4'hF) bad++;
    end
    chk("sel_nohit", 32'(bad), 32'd0);
    wait_idle("sel_idle");
    col = 4'b0011;
    push(0, 4'h6, drv, acc);
    q.push_back('{val: 4'b1101, len: 8, start: drv + 3});
    wait_idle("multi_col_idle");

    // Queue full: five back-to-back pushes, sixth waits for a pop
    col = 4'b0000;
    codes[0] = 4'h0; codes[1] = 4'h5; codes[2] = 4'hA;
    codes[3] = 4'hF; codes[4] = 4'h3; codes[5] = 4'hC;
    rows[0] = 4'b1110; rows[1] = 4'b1101; rows[2] = 4'b1011;
    rows[3] = 4'b0111; rows[4] = 4'b1110; rows[5] = 4'b0111;
    c0 = 0;
    for (int k = 0; k < 5; k++) begin
      push(0, codes[k], drv, acc);
      if (k == 0) c0 = drv;
      chk("burst_accept", 32'(acc), 32'(c0 + k + 1));
    end
    for (int k = 0; k < 6; k++)
      q.push_back('{val: rows[k], len: 8, start: c0 + 3 + 17 * k});
    @(negedge clk);
    chk("full_ready", 32'(key_ready), 32'd0);
    push(0, codes[5], drv, acc);
    chk("sixth_accept", 32'(acc), 32'(c0 + 20));
    wait_idle("burst_idle");

    // Reset in cycle 4 of a press with two keys queued
    push(0, 4'h9, drv, acc);
    c0 = drv;
    push(0, 4'h4, drv, acc);
    push(0, 4'hE, drv, acc);
    q.push_back('{val: 4'b1011, len: 3, start: c0 + 3});
    while (cyc < c0 + 5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_fila", 32'(fila), 32'hF);
    chk("midrst_press", 32'(press_active), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    chk("midrst_stays_idle", 32'(busy), 32'd0);

    // Active-high instance
    col_h = 4'b1000;
    push(1, 4'hF, drv, acc);
    n_on = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fila_h === 4'b1000) n_on++;
      else if (fila_h !== 4'h0) bad++;
    end
    chk("hi_press_len", 32'(n_on), 32'd8);
    chk("hi_other", 32'(bad), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
